// File: rtl/hs_pulse_rx.sv
// hs_pulse_rx: four-phase req/ack receiver with bundled data.
// Synchronises req_a, delivers data_a downstream, returns ack_b.
// Ports: clkb, rst (sync, active-high); req_a, data_a in;
//   ack_b out; data_outb/valid_outb/ready_inb downstream;
//   pulse_outb, err_outb strobes; busy_b; evt_cnt.
// Macro HS_PULSE_RX_CNT_EN builds the evt_cnt counter,
//   otherwise evt_cnt is tied to 0.
module hs_pulse_rx #(
  parameter int SYNC_STAGES = 2,
  parameter int DW          = 8,
  parameter int CW          = 16
) (
  input  logic          clkb,
  input  logic          rst,
  input  logic          req_a,
  input  logic [DW-1:0] data_a,
  output logic          ack_b,
  output logic [DW-1:0] data_outb,
  output logic          valid_outb,
  input  logic          ready_inb,
  output logic          pulse_outb,
  output logic          err_outb,
  output logic          busy_b,
  output logic [CW-1:0] evt_cnt
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DELIVER = 2'd1,
    ACK     = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   req_s;

  logic          ack_q, ack_d;
  logic          valid_q, valid_d;
  logic          pulse_q, pulse_d;
  logic          err_q, err_d;
  logic [DW-1:0] data_q, data_d;
  logic          xfer;

  assign req_s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clkb) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], req_a};
    end
  end

  always_ff @(posedge clkb) begin
    if (rst) begin
      state_q <= IDLE;
      ack_q   <= 1'b0;
      valid_q <= 1'b0;
      pulse_q <= 1'b0;
      err_q   <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      valid_q <= valid_d;
      pulse_q <= pulse_d;
      err_q   <= err_d;
      data_q  <= data_d;
    end
  end

  // Outputs are computed here and registered, so ack_b and the
  // strobes come straight from flops.
  always_comb begin
    state_d = state_q;
    ack_d   = ack_q;
    valid_d = valid_q;
    pulse_d = 1'b0;
    err_d   = 1'b0;
    data_d  = data_q;
    xfer    = 1'b0;
    unique case (state_q)
      IDLE: begin
        ack_d   = 1'b0;
        valid_d = 1'b0;
        if (req_s) begin
          state_d = DELIVER;
          data_d  = data_a;
          valid_d = 1'b1;
          pulse_d = 1'b1;
        end
      end
      DELIVER: begin
        // A ready in the same cycle as the request drop still
        // completes the transfer rather than aborting it.
        if (valid_q && ready_inb) begin
          xfer    = 1'b1;
          state_d = ACK;
          valid_d = 1'b0;
          ack_d   = 1'b1;
        end else if (!req_s) begin
          state_d = IDLE;
          valid_d = 1'b0;
          err_d   = 1'b1;
        end
      end
      ACK: begin
        if (!req_s) begin
          state_d = IDLE;
          ack_d   = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        ack_d   = 1'b0;
        valid_d = 1'b0;
      end
    endcase
  end

`ifdef HS_PULSE_RX_CNT_EN
  logic [CW-1:0] cnt_q;

  always_ff @(posedge clkb) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (xfer) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign evt_cnt = cnt_q;
`else
  logic unused_xfer;

  assign unused_xfer = xfer;
  assign evt_cnt     = '0;
`endif

  assign ack_b      = ack_q;
  assign valid_outb = valid_q;
  assign pulse_outb = pulse_q;
  assign err_outb   = err_q;
  assign data_outb  = data_q;
  assign busy_b     = (state_q != IDLE);

endmodule

// File: tb/tb_hs_pulse_rx.sv
// tb_hs_pulse_rx: directed vector bench for hs_pulse_rx.
// Table of per-cycle inputs/outputs plus a wrap sequence.
module tb_hs_pulse_rx;

  logic       clkb = 1'b0;
  logic       rst = 1'b1;
  logic       req_a = 1'b0;
  logic [7:0] data_a = '0;
  logic       ack_b;
  logic [7:0] data_outb;
  logic       valid_outb;
  logic       ready_inb = 1'b0;
  logic       pulse_outb;
  logic       err_outb;
  logic       busy_b;
  logic [3:0] evt_cnt;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clkb = ~clkb;

  hs_pulse_rx #(
    .SYNC_STAGES(2),
    .DW(8),
    .CW(4)
  ) dut (
    .clkb(clkb),
    .rst(rst),
    .req_a(req_a),
    .data_a(data_a),
    .ack_b(ack_b),
    .data_outb(data_outb),
    .valid_outb(valid_outb),
    .ready_inb(ready_inb),
    .pulse_outb(pulse_outb),
    .err_outb(err_outb),
    .busy_b(busy_b),
    .evt_cnt(evt_cnt)
  );

  typedef struct {
    logic       rst;
    logic       req;
    logic       rdy;
    logic [7:0] din;
    logic       valid;
    logic       pulse;
    logic       ack;
    logic       err;
    logic       busy;
    logic [7:0] dout;
    logic [3:0] cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [3:0] cnt_exp(input int c);
`ifdef HS_PULSE_RX_CNT_EN
    return 4'(c);
`else
    return 4'(c * 0);
`endif
  endfunction

  function automatic void r(
    input logic rs, input logic rq, input logic rd,
    input logic [7:0] di,
    input logic v, input logic p, input logic a,
    input logic e, input logic b,
    input logic [7:0] dq, input int c
  );
    vec_t t;
    t.rst = rs; t.req = rq; t.rdy = rd; t.din = di;
    t.valid = v; t.pulse = p; t.ack = a; t.err = e;
    t.busy = b; t.dout = dq; t.cnt = cnt_exp(c);
    vecs.push_back(t);
  endfunction

  task automatic step();
    @(posedge clkb);
    #1;
  endtask

  task automatic check(input string nm, input vec_t x);
    n_vec++;
    if (valid_outb !== x.valid || pulse_outb !== x.pulse ||
        ack_b !== x.ack || err_outb !== x.err ||
        busy_b !== x.busy || data_outb !== x.dout ||
        evt_cnt !== x.cnt) begin
      n_bad++;
      $display("FAIL %s got v%b p%b a%b e%b b%b d%h c%0d need v%b p%b a%b e%b b%b d%h c%0d",
        nm, valid_outb, pulse_outb, ack_b, err_outb, busy_b,
        data_outb, evt_cnt, x.valid, x.pulse, x.ack, x.err,
        x.busy, x.dout, x.cnt);
    end
  endtask

  initial begin
    // reset
    r(1,0,0,8'h00, 0,0,0,0,0,8'h00,0);
    r(1,0,0,8'h00, 0,0,0,0,0,8'h00,0);
    // basic handshake, A5
    r(0,1,1,8'hA5, 0,0,0,0,0,8'h00,0);
    r(0,1,1,8'hA5, 0,0,0,0,0,8'h00,0);
    r(0,1,1,8'hA5, 1,1,0,0,1,8'hA5,0);
    r(0,1,1,8'hA5, 0,0,1,0,1,8'hA5,1);
    r(0,0,0,8'h00, 0,0,1,0,1,8'hA5,1);
    r(0,0,0,8'h00, 0,0,1,0,1,8'hA5,1);
    r(0,0,0,8'h00, 0,0,0,0,0,8'hA5,1);
    // backpressure, data held
    r(0,1,0,8'h3C, 0,0,0,0,0,8'hA5,1);
    r(0,1,0,8'h3C, 0,0,0,0,0,8'hA5,1);
    r(0,1,0,8'h3C, 1,1,0,0,1,8'h3C,1);
    for (int i = 0; i < 10; i++)
      r(0,1,0,8'hFF, 1,0,0,0,1,8'h3C,1);
    r(0,1,1,8'hFF, 0,0,1,0,1,8'h3C,2);
    r(0,0,0,8'h00, 0,0,1,0,1,8'h3C,2);
    r(0,0,0,8'h00, 0,0,1,0,1,8'h3C,2);
    r(0,0,0,8'h00, 0,0,0,0,0,8'h3C,2);
    // abort
    r(0,1,0,8'h5A, 0,0,0,0,0,8'h3C,2);
    r(0,1,0,8'h5A, 0,0,0,0,0,8'h3C,2);
    r(0,1,0,8'h5A, 1,1,0,0,1,8'h5A,2);
    r(0,0,0,8'h5A, 1,0,0,0,1,8'h5A,2);
    r(0,0,0,8'h5A, 1,0,0,0,1,8'h5A,2);
    r(0,0,0,8'h00, 0,0,0,1,0,8'h5A,2);
    r(0,0,0,8'h00, 0,0,0,0,0,8'h5A,2);
    // drop coincides with ready
    r(0,1,0,8'h77, 0,0,0,0,0,8'h5A,2);
    r(0,1,0,8'h77, 0,0,0,0,0,8'h5A,2);
    r(0,1,0,8'h77, 1,1,0,0,1,8'h77,2);
    r(0,0,0,8'h77, 1,0,0,0,1,8'h77,2);
    r(0,0,0,8'h77, 1,0,0,0,1,8'h77,2);
    r(0,0,1,8'h00, 0,0,1,0,1,8'h77,3);
    r(0,0,0,8'h00, 0,0,0,0,0,8'h77,3);
    // reset in ACK with req held
    r(0,1,1,8'h11, 0,0,0,0,0,8'h77,3);
    r(0,1,1,8'h11, 0,0,0,0,0,8'h77,3);
    r(0,1,1,8'h11, 1,1,0,0,1,8'h11,3);
    r(0,1,1,8'h11, 0,0,1,0,1,8'h11,4);
    r(1,1,1,8'h11, 0,0,0,0,0,8'h00,0);
    r(0,1,1,8'h11, 0,0,0,0,0,8'h00,0);
    r(0,1,1,8'h11, 0,0,0,0,0,8'h00,0);
    r(0,1,1,8'h11, 1,1,0,0,1,8'h11,0);
    r(0,1,1,8'h11, 0,0,1,0,1,8'h11,1);
    r(0,0,0,8'h00, 0,0,1,0,1,8'h11,1);
    r(0,0,0,8'h00, 0,0,1,0,1,8'h11,1);
    r(0,0,0,8'h00, 0,0,0,0,0,8'h11,1);

    foreach (vecs[i]) begin
      @(negedge clkb);
      rst = vecs[i].rst;
      req_a = vecs[i].req;
      ready_inb = vecs[i].rdy;
      data_a = vecs[i].din;
      step();
      check($sformatf("vec%0d", i), vecs[i]);
    end

    // 17 back-to-back handshakes: counter wraps 15 -> 0 -> 1
    @(negedge clkb);
    rst = 1'b1; req_a = 1'b0; ready_inb = 1'b0;
    step();
    @(negedge clkb);
    rst = 1'b0;
    for (int h = 0; h < 17; h++) begin
      int k;
      @(negedge clkb);
      req_a = 1'b1; ready_inb = 1'b1;
      data_a = 8'(h + 8'h40);
      k = 0;
      while (ack_b !== 1'b1 && k < 12) begin
        step();
        k++;
      end
      n_vec++;
      if (ack_b !== 1'b1 || evt_cnt !== cnt_exp(h + 1)) begin
        n_bad++;
        $display("FAIL wrap%0d got ack %b cnt %0d need ack 1 cnt %0d",
          h, ack_b, evt_cnt, cnt_exp(h + 1));
      end
      @(negedge clkb);
      req_a = 1'b0; ready_inb = 1'b0;
      k = 0;
      while ((ack_b !== 1'b0 || busy_b !== 1'b0) && k < 12) begin
        step();
        k++;
      end
      if (ack_b !== 1'b0 || busy_b !== 1'b0) begin
        n_vec++;
        n_bad++;
        $display("FAIL wrap%0d_release got ack %b busy %b need 0 0",
          h, ack_b, busy_b);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/hs_pulse_rx.md
HS_PULSE_RX -- requirements
Module: hs_pulse_rx

Interface
REQ-001 Parameter SYNC_STAGES, default 2, req_a synchronizer depth; legal 2..4.
REQ-002 Parameter DW, default 8, bundled data width.
REQ-003 Parameter CW, default 16, transfer counter width.
REQ-004 clkb  input  1  sole clock; all logic on its rising edge.
REQ-005 rst  input  1  reset; synchronous, active-high.
REQ-006 req_a  input  1  asynchronous four-phase request level from the initiator domain.
REQ-007 data_a  input  DW  bundled data, stable while req_a high.
REQ-008 ack_b  output  1  four-phase acknowledge level returned to the initiator.
REQ-009 data_outb  output  DW  captured data to downstream.
REQ-010 valid_outb  output  1  data_outb valid.
REQ-011 ready_inb  input  1  downstream ready.
REQ-012 pulse_outb  output  1  one-cycle strobe on each request acceptance.
REQ-013 err_outb  output  1  one-cycle strobe on aborted request.
REQ-014 busy_b  output  1  high whenever FSM not in IDLE.
REQ-015 evt_cnt  output  CW  completed-transfer count.

Function
REQ-016 req_a shall pass through a SYNC_STAGES-deep flop chain; FSM uses only the last stage (req_s).
REQ-017 FSM states shall be IDLE, DELIVER, ACK; encoding free.
REQ-018 IDLE: req_s=1 -> DELIVER, load data_a into data_outb, assert valid_outb and pulse_outb.
REQ-019 Latency: valid_outb/pulse_outb rise SYNC_STAGES edges after the first edge sampling req_a=1.
REQ-020 pulse_outb shall be high for exactly one cycle, on DELIVER entry only.
REQ-021 data_outb shall hold constant while valid_outb is high.
REQ-022 DELIVER: valid_outb & ready_inb at an edge = transfer; next state ACK, valid_outb low, ack_b high.
REQ-023 DELIVER: req_s=0 with ready_inb=0 = abort; next state IDLE, valid_outb low, err_outb high one cycle, ack_b stays low, no count.
REQ-024 DELIVER: req_s=0 with ready_inb=1 in same cycle = transfer completes (REQ-022); no error.
REQ-025 ACK: hold ack_b high until req_s=0; on that edge ack_b low, next state IDLE.
REQ-026 ack_b falls SYNC_STAGES edges after the first edge sampling req_a=0.
REQ-027 IDLE shall not accept a new request until req_s has been observed 0 since the last ACK (guaranteed by REQ-025).
REQ-028 evt_cnt increments by 1 on each transfer edge; wraps 2^CW-1 -> 0.
REQ-029 ack_b shall be registered, glitch-free.

Reset
REQ-030 rst=1 at an edge: FSM IDLE, sync chain 0, ack_b 0, valid_outb 0, pulse_outb 0, err_outb 0, busy_b 0, data_outb 0, evt_cnt 0.
REQ-031 Reset mid-transfer shall abandon it silently (no err_outb); if req_a still high after release, it is accepted as a new request.

Configuration
REQ-032 Macro HS_PULSE_RX_CNT_EN defined: evt_cnt counter built per REQ-028.
REQ-033 Macro undefined: no counter flops; evt_cnt tied to 0; all else unchanged.

Verification
REQ-034 SYNC_STAGES=2, req_a=1 with data_a=8'hA5, ready_inb=1 -> pulse_outb/valid_outb high 2 edges later with data_outb=A5; ack_b high next edge; req_a=0 -> ack_b low 2 edges later; evt_cnt=1.
REQ-035 ready_inb=0 for 10 cycles after valid -> valid_outb held, data_outb stable, ack_b low; ready_inb=1 -> ack_b high next edge.
REQ-036 req_a dropped in DELIVER with ready_inb=0 -> err_outb one-cycle pulse, valid_outb low, evt_cnt unchanged, FSM IDLE.
REQ-037 req_a drop coinciding with ready_inb=1 -> transfer counted, no err_outb, ack_b pulses high one cycle then low.
REQ-038 CW=4, 17 back-to-back handshakes -> evt_cnt wraps 15 -> 0 -> 1; with macro undefined evt_cnt stays 0.
REQ-039 rst asserted in ACK with req_a held high -> all outputs 0 next edge; after release, new pulse_outb SYNC_STAGES+1 edges later.
